// File: rtl/seg7_src_sched_pkg.sv
// seg7_src_sched_pkg: shared seven-segment word width and scheduler state encoding
package seg7_src_sched_pkg;
  localparam int SEG7_DW = 32;
  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_OVR} state_t;
endpackage

// File: rtl/seg7_src_sched_btn_debounce.sv
// btn_debounce: synchronise a raw button, debounce it and emit a one-cycle press pulse
// Ports: CLK, reset (async, active-high), btn (raw input), pulse (one cycle on accepted press)
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0] sync, warm;
  logic [CW-1:0] cnt;
  logic level, armed, flip;
  assign flip = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
  // armed only once a released button has been seen through a filled synchroniser,
  // so a button held across reset cannot produce a press
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      sync  <= '0;
      warm  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      warm  <= {warm[0], 1'b1};
      cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync[1] : level;
      armed <= armed | (warm[1] & ~sync[1]);
      pulse <= flip & sync[1] & armed;
    end
endmodule

// File: rtl/seg7_src_sched.sv
// seg7_src_sched: schedule N_SRC requesters onto the single seven-segment display word
// Ports: CLK, reset (async, active-high); src_valid/src_data (requester flags and words);
//   btn_next (raw next button), mode_auto (auto-rotate switch), ovr_req (force source 0);
//   o_data/o_src (registered word and index shown), o_upd (pulse when o_src changes)
module seg7_src_sched
  import seg7_src_sched_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DEB_CYCLES   = 1_000_000
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [SEG7_DW*N_SRC-1:0] src_data,
  input  logic                     btn_next,
  input  logic                     mode_auto,
  input  logic                     ovr_req,
  output logic [SEG7_DW-1:0]       o_data,
  output logic [SEL_W-1:0]         o_src,
  output logic                     o_upd
);
  localparam int DW_W = $clog2(DWELL_CYCLES);
  state_t state, state_n;
  logic [1:0] mode_sync;
  logic btn_pulse, adv;
  logic [DW_W-1:0] dwell, dwell_n;
  logic [SEL_W-1:0] saved, saved_n, src_n, nv;
  // scan from farthest to nearest so the nearest valid index wins
  function automatic logic [SEL_W-1:0] next_valid(input logic [SEL_W-1:0] sel, input logic [N_SRC-1:0] v);
    next_valid = sel;
    for (int k = N_SRC - 1; k >= 1; k--)
      if (v[SEL_W'(sel + k)]) next_valid = SEL_W'(sel + k);
  endfunction
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .CLK  (CLK),
    .reset(reset),
    .btn  (btn_next),
    .pulse(btn_pulse)
  );
  always_comb begin
    nv      = next_valid(o_src, src_valid);
    adv     = !src_valid[o_src] || btn_pulse || (state == ST_AUTO && dwell == DW_W'(DWELL_CYCLES - 1));
    state_n = mode_sync[1] ? ST_AUTO : ST_MANUAL;
    saved_n = saved;
    src_n   = adv ? nv : o_src;
    dwell_n = (state == ST_AUTO && !adv) ? dwell + 1'b1 : '0;
    if (ovr_req) begin
      state_n = ST_OVR;
      saved_n = state == ST_OVR ? saved : o_src;
      src_n   = '0;
      dwell_n = dwell;
    end else if (state == ST_OVR) begin
      src_n   = saved;
      dwell_n = '0;
    end
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state     <= ST_MANUAL;
      mode_sync <= '0;
      dwell     <= '0;
      saved     <= '0;
      o_src     <= '0;
      o_data    <= '0;
      o_upd     <= 1'b0;
    end else begin
      state     <= state_n;
      mode_sync <= {mode_sync[0], mode_auto};
      dwell     <= dwell_n;
      saved     <= saved_n;
      o_src     <= src_n;
      o_upd     <= src_n != o_src;
      if (src_n != o_src || src_valid[src_n]) o_data <= src_data[SEG7_DW*src_n +: SEG7_DW];
    end
endmodule

// File: tb/tb_seg7_src_sched.sv
// tb_seg7_src_sched: directed self-checking bench for seg7_src_sched
module tb_seg7_src_sched;
  logic CLK = 1'b0, reset = 1'b1, btn_next = 1'b0, mode_auto = 1'b0, ovr_req = 1'b0;
  logic [3:0] src_valid = 4'hF;
  logic [127:0] src_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  logic [31:0] o_data;
  logic [1:0] o_src;
  logic o_upd;
  int n_cmp = 0, n_bad = 0, cyc;
  always #5 CLK = ~CLK;
  seg7_src_sched #(.N_SRC(4), .SEL_W(2), .DWELL_CYCLES(8), .DEB_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .btn_next(btn_next), .mode_auto(mode_auto), .ovr_req(ovr_req),
    .o_data(o_data), .o_src(o_src), .o_upd(o_upd)
  );
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_upd(output int n);
    n = 0;
    do begin tick(1); n++; end while (!o_upd && n < 64);
  endtask
  initial begin
    tick(2);
    chk("rst_data", o_data, 0);
    chk("rst_src", o_src, 0);
    chk("rst_upd", o_upd, 0);
    reset = 1'b0;
    tick(1);
    chk("init_data", o_data, 32'h11111111);
    chk("init_src", o_src, 0);
    btn_next = 1'b1;
    tick(6);
    chk("press_wait_src", o_src, 0);
    tick(1);
    chk("press_src", o_src, 1);
    chk("press_upd", o_upd, 1);
    chk("press_data", o_data, 32'h22222222);
    tick(1);
    chk("press_upd_once", o_upd, 0);
    tick(2);
    btn_next = 1'b0;
    tick(10);
    chk("release_src", o_src, 1);
    btn_next = 1'b1;
    tick(2);
    btn_next = 1'b0;
    tick(10);
    chk("glitch_src", o_src, 1);
    mode_auto = 1'b1;
    src_valid = 4'b1011;
    wait_upd(cyc);
    chk("auto_first_cyc", cyc, 11);
    chk("auto_skip2", o_src, 3);
    chk("auto_data3", o_data, 32'h44444444);
    wait_upd(cyc);
    chk("auto_dwell_a", cyc, 8);
    chk("auto_src0", o_src, 0);
    wait_upd(cyc);
    chk("auto_dwell_b", cyc, 8);
    chk("auto_src1", o_src, 1);
    wait_upd(cyc);
    chk("auto_dwell_c", cyc, 8);
    chk("auto_src3", o_src, 3);
    src_valid = 4'b0011;
    tick(1);
    chk("inval_src", o_src, 0);
    chk("inval_upd", o_upd, 1);
    chk("inval_data", o_data, 32'h11111111);
    src_valid = 4'b1111;
    tick(1);
    btn_next = 1'b1;
    tick(6);
    chk("coin_hold", o_src, 0);
    tick(1);
    chk("coin_single", o_src, 1);
    chk("coin_upd", o_upd, 1);
    tick(7);
    chk("coin_restart_hold", o_src, 1);
    tick(1);
    chk("coin_restart_src", o_src, 2);
    btn_next = 1'b0;
    wait_upd(cyc);
    chk("pre_ovr_cyc", cyc, 8);
    chk("pre_ovr_src", o_src, 3);
    ovr_req = 1'b1;
    tick(1);
    chk("ovr_src", o_src, 0);
    chk("ovr_upd", o_upd, 1);
    chk("ovr_data", o_data, 32'h11111111);
    btn_next = 1'b1;
    tick(8);
    btn_next = 1'b0;
    tick(8);
    chk("ovr_btn_ignored", o_src, 0);
    chk("ovr_upd_quiet", o_upd, 0);
    ovr_req = 1'b0;
    tick(1);
    chk("ovr_exit_src", o_src, 3);
    chk("ovr_exit_upd", o_upd, 1);
    chk("ovr_exit_data", o_data, 32'h44444444);
    wait_upd(cyc);
    chk("ovr_exit_dwell", cyc, 8);
    chk("ovr_exit_next", o_src, 0);
    mode_auto = 1'b0;
    btn_next = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_src", o_src, 0);
    chk("mid_rst_upd", o_upd, 0);
    reset = 1'b0;
    tick(15);
    chk("held_src", o_src, 0);
    chk("held_data", o_data, 32'h11111111);
    btn_next = 1'b0;
    tick(10);
    btn_next = 1'b1;
    tick(6);
    chk("repress_wait", o_src, 0);
    tick(1);
    chk("repress_src", o_src, 1);
    chk("repress_upd", o_upd, 1);
    chk("repress_data", o_data, 32'h22222222);
    btn_next = 1'b0;
    src_valid = 4'b0000;
    src_data[63:32] = 32'hDEADBEEF;
    tick(5);
    chk("none_src", o_src, 1);
    chk("none_data", o_data, 32'h22222222);
    chk("none_upd", o_upd, 0);
    src_valid = 4'b0010;
    tick(1);
    chk("live_data", o_data, 32'hDEADBEEF);
    chk("live_src", o_src, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
